// File: rtl/light_dance.sv
// -----------------------------------------------------------------------------
// light_dance
// Serial-in / parallel-load shift register that drives a row of lights.
// A pattern is loaded from pdata and then marches one position toward the
// LSB every clock, with din entering at the MSB. qdata is the register itself,
// so there is no combinational path from any input to the lights.
//
// Optional build macro: LIGHTDANCE_ROTATE_EN
//   Adds the rot input. With load=0 and rot=1 the register rotates right
//   (the LSB wraps to the MSB) and din is ignored. load keeps priority.
// -----------------------------------------------------------------------------
module light_dance #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             din,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
`ifdef LIGHTDANCE_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] qdata
);

    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] pattern_d;

    // Next pattern: a parallel load wins, otherwise shift (or rotate) right.
    always_comb begin
        // NOTE: pattern_d gets a value on every path before any branch, so no latch can be inferred.
        pattern_d = {din, pattern_q[WIDTH-1:1]};
        if (load) begin
            pattern_d = pdata;
        end else begin
`ifdef LIGHTDANCE_ROTATE_EN
            if (rot) begin
                pattern_d = {pattern_q[0], pattern_q[WIDTH-1:1]};
            end
`else
            // Plain build: every non-load cycle is a serial shift from din.
            pattern_d = {din, pattern_q[WIDTH-1:1]};
`endif
        end
    end

    // Pattern register; an active-low arst turns every light off immediately.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pattern_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            pattern_q <= pattern_d;
        end
    end

    assign qdata = pattern_q;

endmodule

// File: tb/tb_light_dance.sv
// -----------------------------------------------------------------------------
// tb_light_dance
// Directed, table-driven bench for light_dance. Each table row is applied for
// one rising edge and qdata is compared one time unit later. Reset behaviour
// is covered by hand-written sequences. Rotate rows run only when
// LIGHTDANCE_ROTATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_light_dance;

    localparam int WIDTH = 8;

    logic             clk;
    logic             arst;
    logic             din;
    logic             load;
    logic [WIDTH-1:0] pdata;
    logic             rot;
    logic [WIDTH-1:0] qdata;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic             ld;
        logic             d;
        logic             r;
        logic [WIDTH-1:0] pd;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    light_dance #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .arst  (arst),
        .din   (din),
        .load  (load),
        .pdata (pdata),
`ifdef LIGHTDANCE_ROTATE_EN
        .rot   (rot),
`endif
        .qdata (qdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: qdata=0x%02h expected 0x%02h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Apply inputs, take one rising edge, settle one time unit after it.
    task automatic step(input logic ld, input logic d, input logic r,
                        input logic [WIDTH-1:0] pd);
        load  = ld;
        din   = d;
        rot   = r;
        pdata = pd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        arst  = 1'b0;
        din   = 1'b0;
        load  = 1'b0;
        pdata = '0;
        rot   = 1'b0;

        // ---------------- reset sequences ----------------
        #2;
        check("reset_initial", qdata, 8'h00);

        // Reset held across edges with load=1 and an all-ones pattern.
        load  = 1'b1;
        pdata = 8'hFF;
        din   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_holds_vs_load", qdata, 8'h00);

        // Release reset away from the edge; first update is the next edge.
        @(negedge clk);
        arst = 1'b1;
        #1;
        check("release_no_edge", qdata, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        check("first_load_after_release", qdata, 8'hA5);

        // Asynchronous assertion mid-cycle clears without a clock edge.
        @(negedge clk);
        #1;
        arst = 1'b0;
        #1;
        check("async_clear_midcycle", qdata, 8'h00);
        load  = 1'b1;
        pdata = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("async_hold_load_ff", qdata, 8'h00);

        // Undefined pattern/din while in reset must not reach the register.
        pdata = 'x;
        din   = 1'bx;
        @(posedge clk);
        #1;
        check("x_inputs_in_reset", qdata, 8'h00);
        @(negedge clk);
        arst = 1'b1;

        // ---------------- table-driven vectors ----------------
        // Load 0xD5 with din=1 (ignored), then shift in ones.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hD5, 8'hD5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hEA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hF5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hFA});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hFD});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hFE});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF});
        // Load 0xD5, then eight shifts of zeros drain to 0x00.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hD5, 8'hD5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h6A});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h35});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h1A});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h0D});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h06});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h03});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h01});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        // Load wins over din; pdata ignored while shifting.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'hFF, 8'h9E});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hFF, 8'h4F});
        // Loading zero clears even with din=1.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h80});
`ifdef LIGHTDANCE_ROTATE_EN
        // Rotate a single lit light all the way round.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 8'h01});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h80});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h40});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h20});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h10});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h08});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h04});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h02});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h01});
        // Rotate ignores din; load beats rot; rot=0 shifts normally.
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'hD5, 8'hD5});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'hEA});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 8'h75});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h3A});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].d, vecs[i].r, vecs[i].pd);
            check($sformatf("vec%0d", i), qdata, vecs[i].exp);
        end

        // ---------------- reset aborting a load ----------------
        load  = 1'b1;
        pdata = 8'hC3;
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_aborts_load", qdata, 8'h00);
        @(negedge clk);
        arst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("shift_after_reset", qdata, 8'h80);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/light_dance.md
Name: light_dance

Overview:
- Serial-in / parallel-load 8-bit shift register driving a row of lights (LED "dance" patterns) in the smart-home lighting subsystem.
- Software or a controller loads a pattern via pdata. The pattern then marches one position per clock, with new bits entering serially from din.
- qdata drives the light outputs directly from the register.

Parameters:
- WIDTH, 8, register/light count; pdata and qdata are WIDTH bits wide. All values below assume 8.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- arst  input  1  asynchronous reset, active-low (arst=0 clears the register immediately, independent of clk)
- din  input  1  serial data bit shifted into the MSB
- load  input  1  synchronous parallel-load strobe, active-high
- pdata  input  WIDTH  parallel pattern, captured when load=1
- qdata  output  WIDTH  current register contents, registered output

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - While arst=0, qdata=0 (all lights off); the register is held there.
  - Reset assertion takes effect without a clock edge.
  - Deassertion is sampled at the next rising clk; the first functional update happens on the first rising edge with arst=1.
- Each rising clk with arst=1, priority order:
  - load=1: qdata <= pdata, and din is ignored that cycle.
  - load=0: shift right, qdata <= {din, qdata[WIDTH-1:1]}; qdata[0] is discarded.
- No hold state: with load=0 the register shifts every cycle.
- Latency: a pdata or din change is visible on qdata one clock after the sampling edge. No combinational path from any input to qdata.
- After WIDTH consecutive shifts with constant din, qdata = all-din (0xFF for din=1, 0x00 for din=0).
- Reset mid-operation: arst=0 during a load or shift aborts it; qdata=0 regardless of load/din/pdata.
- X/undefined din or pdata while arst=0 does not propagate; the register remains 0.

Optional Feature:
- Macro: LIGHTDANCE_ROTATE_EN
- Defined:
  - Adds input port rot (1 bit, after pdata).
  - When load=0 and rot=1: circular rotate right, qdata <= {qdata[0], qdata[WIDTH-1:1]}; din is ignored.
  - load still has priority over rot.
  - rot=0 gives the normal shift.
- Not defined:
  - No rot port; behaviour is exactly the shift/load described above.

Test Plan:
1. arst=0 asynchronously mid-cycle with qdata=0xA5 -> qdata=0x00 immediately, stays 0x00 across edges while arst=0 despite load=1, pdata=0xFF.
2. arst=1, load=1, pdata=0xD5, one edge -> qdata=0xD5; din=1 during that edge has no effect.
3. After load 0xD5, load=0, din=1 -> successive edges give 0xEA, 0xF5, 0xFA, 0xFD, 0xFE, 0xFF, 0xFF.
4. After load 0xD5, load=0, din=0 -> 0x6A, 0x35, 0x1A; after 8 shifts 0x00.
5. load=1 and din toggling simultaneously, pdata=0x3C -> qdata=0x3C (load wins); next edge load=0, din=1 -> 0x9E.
6. With LIGHTDANCE_ROTATE_EN: load 0x01, rot=1, din=0 -> 0x80, 0x40, …; after 8 edges back to 0x01. Load 0xD5, rot=1 -> 0xEA.
